// File: rtl/cond_unit_pkg.sv
// Shared CPU definitions: condition codes and the bit positions of N,Z,C,V
// within the architectural flags register.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Combinational condition evaluation of a 4-bit condition code against {N,Z,C,V}.
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_pass = 1'b0;
        case (cond_e'(i_cond))
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition/flags stage: evaluates the condition against the architectural flags,
// updates the flags and registers the gated result toward memory/writeback.
module cond_unit
    import cond_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [1:0]  flag_write,
    input  logic [3:0]  alu_flags,
    input  logic [31:0] alu_result,
    input  logic [3:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_write_in,
    input  logic        pc_src_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_rd,
    output logic        reg_write,
    output logic        mem_write,
    output logic        pc_src,
    output logic        cond_ex,
    output logic [3:0]  flags,
    output logic        carry_to_alu
);

    logic        r_out_valid;
    logic [31:0] r_result;
    logic [3:0]  r_rd;
    logic        r_reg_write;
    logic        r_mem_write;
    logic        r_pc_src;
    logic        r_cond_ex;
    logic [3:0]  r_flags;

    logic        w_pass;
    logic        w_transfer;
    logic [3:0]  w_flags_nxt;

    cond_check u_cond_check (
        .i_cond  (cond),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    assign in_ready   = !r_out_valid || out_ready;
    assign w_transfer = in_valid && in_ready && !flush;

    always_comb begin
        w_flags_nxt = r_flags;
        if (w_transfer && w_pass) begin
            if (flag_write[1]) w_flags_nxt[FLAG_N:FLAG_Z] = alu_flags[FLAG_N:FLAG_Z];
            if (flag_write[0]) w_flags_nxt[FLAG_C:FLAG_V] = alu_flags[FLAG_C:FLAG_V];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_pc_src    <= 1'b0;
            r_cond_ex   <= 1'b0;
            r_flags     <= '0;
        end else begin
            r_flags <= w_flags_nxt;
            if (w_transfer) begin
                r_out_valid <= 1'b1;
                r_result    <= alu_result;
                r_rd        <= rd_in;
                r_reg_write <= reg_write_in && w_pass;
                r_mem_write <= mem_write_in && w_pass;
                r_pc_src    <= pc_src_in && w_pass;
                r_cond_ex   <= w_pass;
            end else if (flush || out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Side-effecting requests are masked once the held instruction has drained or been killed.
    assign reg_write    = r_reg_write && r_out_valid;
    assign mem_write    = r_mem_write && r_out_valid;
    assign pc_src       = r_pc_src && r_out_valid;
    assign out_valid    = r_out_valid;
    assign out_result   = r_result;
    assign out_rd       = r_rd;
    assign cond_ex      = r_cond_ex;
    assign flags        = r_flags;
    assign carry_to_alu = r_flags[FLAG_C];

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized traffic
// compared against a transaction-level model of the flags/output register.
module tb_cond_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  cond = 4'h0;
    logic [1:0]  flag_write = 2'b00;
    logic [3:0]  alu_flags = 4'h0;
    logic [31:0] alu_result = 32'h0;
    logic [3:0]  rd_in = 4'h0;
    logic        reg_write_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        pc_src_in = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        reg_write, mem_write, pc_src, cond_ex;
    logic [3:0]  flags;
    logic        carry_to_alu;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit        m_ov;
    bit [31:0] m_res;
    bit [3:0]  m_rd;
    bit        m_rw, m_mw, m_pc, m_cx;
    bit [3:0]  m_flags;

    always #5 clk = ~clk;

    cond_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .flag_write(flag_write), .alu_flags(alu_flags),
        .alu_result(alu_result), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .mem_write_in(mem_write_in), .pc_src_in(pc_src_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .reg_write(reg_write), .mem_write(mem_write),
        .pc_src(pc_src), .cond_ex(cond_ex), .flags(flags), .carry_to_alu(carry_to_alu)
    );

    logic [44:0] act_vec;
    assign act_vec = {out_valid, out_result, out_rd, reg_write, mem_write, pc_src, cond_ex, flags};

    function automatic bit cpass(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [44:0] exp_vec();
        return {m_ov, m_res, m_rd, m_ov && m_rw, m_ov && m_mw, m_ov && m_pc, m_cx, m_flags};
    endfunction

    task automatic drive(input bit iv, input bit [3:0] c, input bit [1:0] fw, input bit [3:0] af,
                         input bit [31:0] res, input bit [3:0] rd, input bit rw, input bit mw,
                         input bit pc, input bit fl, input bit ordy);
        in_valid = iv; cond = c; flag_write = fw; alu_flags = af; alu_result = res;
        rd_in = rd; reg_write_in = rw; mem_write_in = mw; pc_src_in = pc; flush = fl;
        out_ready = ordy;
        #1;
    endtask

    // Advance the model by one edge using the currently driven inputs, then step the DUT.
    task automatic tick();
        bit accept, p;
        if (reset) begin
            m_ov = 0; m_res = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_pc = 0; m_cx = 0; m_flags = 0;
        end else begin
            accept = in_valid && (!m_ov || out_ready) && !flush;
            if (accept) begin
                p = cpass(cond, m_flags);
                if (p && flag_write[1]) m_flags[3:2] = alu_flags[3:2];
                if (p && flag_write[0]) m_flags[1:0] = alu_flags[1:0];
                m_res = alu_result; m_rd = rd_in; m_cx = p;
                m_rw = reg_write_in && p; m_mw = mem_write_in && p; m_pc = pc_src_in && p;
                m_ov = 1;
            end else if (flush || (m_ov && out_ready)) begin
                m_ov = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 4'hE, 2'b11, 4'hF, 32'hDEADBEEF, 4'h7, 1, 1, 1, 0, 1);
        tick();
        reset = 1'b0;
        n_checks++;
        if (act_vec !== 45'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", act_vec, 45'h0);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_al();
        drive(1, 4'hE, 2'b11, 4'b0100, 32'h1234_5678, 4'h3, 1, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || reg_write !== 1'b1 || flags !== 4'b0100 || out_result !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL al_exec: got ov=%b rw=%b flags=%b res=%h expected ov=1 rw=1 flags=0100 res=12345678",
                     out_valid, reg_write, flags, out_result);
        end
    endtask

    task automatic test_ne_fail();
        drive(1, 4'h1, 2'b11, 4'b1011, 32'hAAAA_0001, 4'h5, 1, 1, 0, 0, 1);
        tick();
        n_checks++;
        if (cond_ex !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0 || flags !== 4'b0100 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ne_blocked: got cx=%b rw=%b mw=%b flags=%b ov=%b expected cx=0 rw=0 mw=0 flags=0100 ov=1",
                     cond_ex, reg_write, mem_write, flags, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 4'hE, 2'b11, 4'b0110, 32'h0, 4'h1, 1, 0, 0, 0, 1);
        tick();
        drive(1, 4'h8, 2'b00, 4'h0, 32'h11, 4'h2, 1, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (cond_ex !== 1'b0 || reg_write !== 1'b0 || flags !== 4'b0110) begin
            n_fail++;
            $display("FAIL b2b_hi: got cx=%b rw=%b flags=%b expected cx=0 rw=0 flags=0110", cond_ex, reg_write, flags);
        end
        drive(1, 4'h2, 2'b00, 4'h0, 32'h22, 4'h3, 1, 0, 1, 0, 1);
        tick();
        n_checks++;
        if (cond_ex !== 1'b1 || reg_write !== 1'b1 || pc_src !== 1'b1 || out_result !== 32'h22) begin
            n_fail++;
            $display("FAIL b2b_cs: got cx=%b rw=%b pc=%b res=%h expected cx=1 rw=1 pc=1 res=22",
                     cond_ex, reg_write, pc_src, out_result);
        end
    endtask

    task automatic test_stall();
        drive(1, 4'hE, 2'b11, 4'b1001, 32'hCAFE_0001, 4'h9, 1, 1, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'hE, 2'b11, 4'b0000, 32'hCAFE_0002 + i, 4'hA, 0, 0, 1, 0, 0);
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready: cycle %0d got %b expected 0", i, in_ready);
            end
            tick();
            n_checks++;
            if (act_vec !== exp_vec() || out_result !== 32'hCAFE_0001 || flags !== 4'b1001) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
        end
        drive(1, 4'hE, 2'b00, 4'h0, 32'hCAFE_0099, 4'hB, 1, 0, 0, 0, 1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'hCAFE_0099 || out_rd !== 4'hB) begin
            n_fail++;
            $display("FAIL stall_release_accept: got ov=%b res=%h rd=%h expected ov=1 res=cafe0099 rd=b",
                     out_valid, out_result, out_rd);
        end
    endtask

    task automatic test_flush();
        drive(1, 4'hE, 2'b11, 4'b1111, 32'h5555, 4'h4, 1, 1, 1, 1, 1);
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || flags !== 4'b1001 || reg_write !== 1'b0 || mem_write !== 1'b0 || pc_src !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got ov=%b flags=%b ctl=%b%b%b expected ov=0 flags=1001 ctl=000",
                     out_valid, flags, reg_write, mem_write, pc_src);
        end
    endtask

    task automatic test_carry();
        drive(1, 4'hE, 2'b11, 4'b0010, 32'h1, 4'h1, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (carry_to_alu !== 1'b1 || flags !== 4'b0010) begin
            n_fail++;
            $display("FAIL carry_out: got c=%b flags=%b expected c=1 flags=0010", carry_to_alu, flags);
        end
        drive(1, 4'hE, 2'b01, 4'b1100, 32'h2, 4'h2, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (flags !== 4'b0000 || carry_to_alu !== 1'b0) begin
            n_fail++;
            $display("FAIL cv_only_write: got flags=%b c=%b expected flags=0000 c=0", flags, carry_to_alu);
        end
    endtask

    task automatic test_reset_in_stall();
        drive(1, 4'hE, 2'b11, 4'b0101, 32'h77, 4'h7, 1, 0, 0, 0, 1);
        tick();
        drive(1, 4'hE, 2'b11, 4'b1111, 32'h88, 4'h8, 1, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (act_vec !== 45'h0) begin
            n_fail++;
            $display("FAIL reset_in_stall: got %h expected %h", act_vec, 45'h0);
        end
    endtask

    task automatic test_random();
        bit [31:0] r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), r, 4'($urandom_range(0, 15)), r[0], r[1], r[2],
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
            n_checks++;
            if (in_ready !== (!m_ov || out_ready) || carry_to_alu !== m_flags[1]) begin
                n_fail++;
                $display("FAIL rand_comb: iter %0d got rdy=%b c=%b expected rdy=%b c=%b",
                         i, in_ready, carry_to_alu, !m_ov || out_ready, m_flags[1]);
            end
            tick();
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_outputs: iter %0d got %h expected %h", i, act_vec, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_al();
        test_ne_fail();
        test_back_to_back();
        test_stall();
        test_flush();
        test_carry();
        test_reset_in_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
